// File: rtl/antidiff_sequencer.sv
// -----------------------------------------------------------------------------
// antidiff_sequencer
//
// Time-multiplexed controller for a cascade of first-order anti-difference
// (running-sum) stages. A single adder and an N-entry accumulator bank stand in
// for N parallel stages. For each accepted sample the active stages are updated
// in order 0..ord-1, one stage per clock. The last stage's sum is presented on
// a valid/ready output.
//
// Parameters:
//   N        maximum number of cascaded stages (1..16)
//   OUT_RES  width of samples, accumulators and result
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset (priority over clear)
//   clear      synchronous accumulator clear / abort of the sample in flight
//   cfg_order  number of active stages, sampled on input acceptance
//   in_valid   input sample valid
//   in_ready   controller is idle and can accept a sample
//   in_data    input sample, two's complement
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   anti-difference of the selected order
//   busy       controller is running or holding a result
// -----------------------------------------------------------------------------
module antidiff_sequencer #(
    parameter int N       = 4,
    parameter int OUT_RES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [$clog2(N):0]     cfg_order,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OUT_RES-1:0]     in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_RES-1:0]     out_data,
    output logic                   busy
);

    localparam int N_BITS = $clog2(N);
    // Index width into the accumulator bank (at least one bit).
    localparam int KW = (N > 1) ? N_BITS : 1;

    localparam logic [N_BITS:0] ORD_MAX = N[N_BITS:0];
    localparam logic [N_BITS:0] ORD_ONE = {{N_BITS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t              state_reg;
    logic [N_BITS:0]     k_reg;
    logic [N_BITS:0]     ord_reg;
    logic [OUT_RES-1:0]  opd_reg;
    logic                out_valid_reg;
    logic [OUT_RES-1:0]  out_data_reg;

    logic [OUT_RES-1:0]  acc_word [N];
    logic [KW-1:0]       k_idx;
    logic [OUT_RES-1:0]  sum;
    logic                last_stage;
    logic [N_BITS:0]     ord_clamp;

    // k never exceeds N-1, so the low bits are a complete bank index.
    assign k_idx      = k_reg[KW-1:0];
    assign sum        = acc_word[k_idx] + opd_reg;
    assign last_stage = (k_reg == (ord_reg - ORD_ONE));

    // Order 0 means a single stage; anything above N saturates at N.
    always_comb begin
        ord_clamp = cfg_order;
        if (cfg_order == '0) begin
            ord_clamp = ORD_ONE;
        end else if (cfg_order > ORD_MAX) begin
            ord_clamp = ORD_MAX;
        end
    end

    // Accumulator bank: each entry is written only when its stage is being
    // processed, so stages beyond the current order keep their values.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_acc
            logic [OUT_RES-1:0] acc_reg;
            logic               stage_sel;

            assign stage_sel    = (state_reg == ST_RUN) && (k_idx == KW'(gi));
            assign acc_word[gi] = acc_reg;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    acc_reg <= '0;
                end else if (stage_sel) begin
                    acc_reg <= sum;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            opd_reg       <= '0;
            k_reg         <= '0;
            ord_reg       <= ORD_ONE;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (clear) begin
            // Abort: the sample in flight is dropped, out_data keeps its value.
            state_reg     <= ST_IDLE;
            opd_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        opd_reg   <= in_data;
                        k_reg     <= '0;
                        ord_reg   <= ord_clamp;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Each stage's output is the next stage's operand.
                    opd_reg <= sum;
                    if (last_stage) begin
                        out_data_reg  <= sum;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_antidiff_sequencer.sv
module tb_antidiff_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [2:0]  cfg_order;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    antidiff_sequencer #(.N(4), .OUT_RES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .cfg_order (cfg_order),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Offers one sample, waits for the result and returns it together with the
    // number of cycles from the acceptance edge to out_valid. If out_ready is
    // high the handshake edge is consumed as well.
    task automatic send(input logic [15:0] d, input logic [2:0] ord,
                        output logic [15:0] res, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        in_data   = d;
        cfg_order = ord;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        res = out_data;
        if (out_ready) tick();
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h busy=%b expected 1 0 0000 0",
                     in_ready, out_valid, out_data, busy);
        end
    endtask

    task automatic test_order1();
        logic [15:0] exp_v [3] = '{16'd1, 16'd3, 16'd6};
        logic [15:0] res;
        int lat;
        pulse_clear();
        for (int i = 0; i < 3; i++) begin
            send(16'(i + 1), 3'd1, res, lat);
            checks++;
            if (res !== exp_v[i] || lat !== 1) begin
                failures++;
                $display("FAIL order1[%0d]: got %h lat %0d expected %h lat 1", i, res, lat, exp_v[i]);
            end
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL order1_idle[%0d]: in_ready=%b expected 1", i, in_ready);
            end
        end
    endtask

    task automatic test_order2();
        logic [15:0] exp_v [3] = '{16'd1, 16'd3, 16'd6};
        logic [15:0] res;
        int lat;
        pulse_clear();
        for (int i = 0; i < 3; i++) begin
            send(16'd1, 3'd2, res, lat);
            checks++;
            if (res !== exp_v[i] || lat !== 2) begin
                failures++;
                $display("FAIL order2[%0d]: got %h lat %0d expected %h lat 2", i, res, lat, exp_v[i]);
            end
        end
        // acc[0]=3: an order-1 zero sample exposes it.
        send(16'd0, 3'd1, res, lat);
        checks++;
        if (res !== 16'd3) begin
            failures++;
            $display("FAIL order2_acc0: got %h expected 0003", res);
        end
        // acc[1]=6: an order-2 zero sample yields 6+3.
        send(16'd0, 3'd2, res, lat);
        checks++;
        if (res !== 16'd9) begin
            failures++;
            $display("FAIL order2_acc1: got %h expected 0009", res);
        end
    endtask

    task automatic test_clamp();
        logic [15:0] res;
        int lat;
        pulse_clear();
        send(16'd1, 3'd7, res, lat);
        checks++;
        if (res !== 16'd1 || lat !== 4) begin
            failures++;
            $display("FAIL clamp_hi0: got %h lat %0d expected 0001 lat 4", res, lat);
        end
        send(16'd1, 3'd7, res, lat);
        checks++;
        if (res !== 16'd5 || lat !== 4) begin
            failures++;
            $display("FAIL clamp_hi1: got %h lat %0d expected 0005 lat 4", res, lat);
        end
        pulse_clear();
        send(16'd4, 3'd0, res, lat);
        checks++;
        if (res !== 16'd4 || lat !== 1) begin
            failures++;
            $display("FAIL clamp_zero0: got %h lat %0d expected 0004 lat 1", res, lat);
        end
        send(16'd0, 3'd0, res, lat);
        checks++;
        if (res !== 16'd4 || lat !== 1) begin
            failures++;
            $display("FAIL clamp_zero1: got %h lat %0d expected 0004 lat 1", res, lat);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] din   [3] = '{16'h7FFF, 16'h0001, 16'h8000};
        logic [15:0] exp_v [3] = '{16'h7FFF, 16'h8000, 16'h0000};
        logic [15:0] res;
        int lat;
        pulse_clear();
        for (int i = 0; i < 3; i++) begin
            send(din[i], 3'd1, res, lat);
            checks++;
            if (res !== exp_v[i]) begin
                failures++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, res, exp_v[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] res;
        int lat;
        pulse_clear();
        out_ready = 1'b0;
        send(16'd3, 3'd2, res, lat);
        checks++;
        if (res !== 16'd3 || lat !== 2) begin
            failures++;
            $display("FAIL bp_result: got %h lat %0d expected 0003 lat 2", res, lat);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_data  = 16'd100;
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'd3 || in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: out_valid=%b out_data=%h in_ready=%b busy=%b expected 1 0003 0 1",
                         i, out_valid, out_data, in_ready, busy);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        // The blocked pulse must not have touched acc[0].
        send(16'd0, 3'd1, res, lat);
        checks++;
        if (res !== 16'd3) begin
            failures++;
            $display("FAIL bp_no_accept: got %h expected 0003", res);
        end
    endtask

    task automatic test_abort();
        logic [15:0] res;
        int lat;
        logic seen;
        pulse_clear();
        in_data   = 16'd7;
        cfg_order = 3'd4;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        tick();
        pulse_clear();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: in_ready=%b busy=%b out_valid=%b expected 1 0 0",
                     in_ready, busy, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_valid: out_valid rose=%b expected 0", seen);
        end
        send(16'd5, 3'd4, res, lat);
        checks++;
        if (res !== 16'd5 || lat !== 4) begin
            failures++;
            $display("FAIL abort_next: got %h lat %0d expected 0005 lat 4", res, lat);
        end
        // Reset while holding a result in DONE.
        out_ready = 1'b0;
        send(16'd9, 3'd1, res, lat);
        checks++;
        if (res !== 16'd14) begin
            failures++;
            $display("FAIL done_result: got %h expected 000e", res);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_done: out_valid=%b out_data=%h in_ready=%b expected 0 0000 1",
                     out_valid, out_data, in_ready);
        end
        send(16'd0, 3'd1, res, lat);
        checks++;
        if (res !== 16'd0) begin
            failures++;
            $display("FAIL reset_acc: got %h expected 0000", res);
        end
    endtask

    task automatic test_clear_priority();
        logic [15:0] res;
        int lat;
        pulse_clear();
        send(16'd8, 3'd1, res, lat);
        checks++;
        if (res !== 16'd8) begin
            failures++;
            $display("FAIL clrpri_pre: got %h expected 0008", res);
        end
        in_data  = 16'd50;
        in_valid = 1'b1;
        clear    = 1'b1;
        tick();
        in_valid = 1'b0;
        clear    = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clrpri_idle: in_ready=%b busy=%b expected 1 0", in_ready, busy);
        end
        send(16'd0, 3'd1, res, lat);
        checks++;
        if (res !== 16'd0) begin
            failures++;
            $display("FAIL clrpri_acc: got %h expected 0000", res);
        end
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        cfg_order = 3'd1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_order1();
        test_order2();
        test_clamp();
        test_wrap();
        test_backpressure();
        test_abort();
        test_clear_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
